secure_lock_regfile: RTL and testbench
======================================

Name: secure_lock_regfile

Overview:
- Parametrised bank of NUM_REGS write-protected configuration registers, each DATA_W bits wide.
- Write access is governed by a key-gated lock state machine. The lock powers up and resets to LOCKED, which is a known, secure default.
- Repeated wrong keys trigger a timed lockout.
- Sits between the debug/JTAG access path and protected configuration state; a generalised successor to the single-register lock.

Parameters:
- NUM_REGS, 4, number of protected registers.
- DATA_W, 8, register width in bits.
- KEY_W, 32, unlock key width.
- UNLOCK_KEY, 32'hA5C3_0F1E, expected key; width KEY_W.
- MAX_FAIL, 3, consecutive wrong keys before lockout (>=1).
- LOCKOUT_CYC, 16, lockout duration in cycles (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write request.
- wr_addr  in  AW=$clog2(NUM_REGS) (min 1)  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  AW  read address.
- rd_data  out  DATA_W  registered read data.
- lock_set  in  1  force relock.
- unlock_req  in  1  unlock attempt strobe.
- unlock_key  in  KEY_W  key presented with unlock_req.
- unlocked  out  1  high in UNLOCKED state.
- lockout  out  1  high in LOCKOUT state.
- wr_err  out  1  one-cycle pulse, write rejected.
- fail_cnt  out  FW=$clog2(MAX_FAIL+1)  consecutive failed attempts.

Behaviour:
- Reset values (synchronous, any state, including mid-CHECK or mid-LOCKOUT):
  - all registers 0; state LOCKED.
  - unlocked, lockout, wr_err, rd_data, fail_cnt, timer all 0.
  - key capture register cleared.
- FSM states: LOCKED, CHECK, UNLOCKED, LOCKOUT.
- LOCKED:
  - unlock_req=1 captures unlock_key into key_q and moves to CHECK.
  - lock_set is a no-op.
- CHECK (exactly 1 cycle; unlock_req ignored):
  - key_q==UNLOCK_KEY: go to UNLOCKED, fail_cnt<=0.
  - Otherwise fail_cnt+1. If the new value equals MAX_FAIL, go to LOCKOUT and load timer with LOCKOUT_CYC-1; else go to LOCKED.
- UNLOCKED:
  - lock_set=1 returns to LOCKED next cycle.
  - unlock_req ignored.
- LOCKOUT:
  - timer decrements each cycle. When timer==0, go to LOCKED and set fail_cnt<=0.
  - unlock_req and lock_set ignored; no key capture.
- Unlock latency: unlocked asserts 2 cycles after the unlock_req cycle.
- Outputs unlocked and lockout are decoded from the registered state (glitch-free).
- Write acceptance: all of the following must hold in the same cycle:
  - wr_en=1;
  - state==UNLOCKED;
  - lock_set=0 (lock_set wins a same-cycle write);
  - wr_addr<NUM_REGS.
- An accepted write updates the register at the next edge.
- Any other wr_en=1 cycle leaves all registers unchanged, and wr_err=1 on the following cycle for exactly one cycle.
- Read path:
  - rd_data <= reg[rd_addr] every cycle, 1-cycle latency.
  - rd_addr>=NUM_REGS returns 0.
  - Reads are never blocked by lock state.
- Read-during-write to the same address returns the old value.
- fail_cnt saturates at MAX_FAIL; it never wraps.
- The key is compared only from key_q, never combinationally from the port.

Decomposition:
- Package secure_lock_pkg holds:
  - lock_state_e enum {LOCKED, CHECK, UNLOCKED, LOCKOUT} (2-bit);
  - default key localparam;
  - AW/FW width helper functions.
- One sub-module, lock_fsm: owns state, key_q, fail_cnt and timer, and outputs write_allow. The top holds the register array, read path and wr_err.

Test Plan:
- Reset, then write 8'h5A to addr 1 while LOCKED -> reg1 stays 0; wr_err pulses 1 cycle; rd_data at addr 1 = 0.
- unlock_req with key 32'hA5C3_0F1E -> unlocked=1 two cycles later. Then write 8'h5A to addr 1 -> rd_data reads 8'h5A.
- Three unlock_req with key 32'h0 -> fail_cnt reaches 1, 2, 3 and lockout=1. A correct key during lockout is ignored. After 16 cycles: lockout=0, fail_cnt=0, LOCKED.
- While UNLOCKED, assert lock_set and wr_en (addr 2, 8'hFF) in the same cycle -> reg2 unchanged, wr_err=1, unlocked=0 next cycle.
- Assert reset mid-LOCKOUT (timer=7) -> next cycle: all registers 0, LOCKED, fail_cnt=0, lockout=0. A correct key then unlocks normally.
- NUM_REGS=5, DATA_W=12: write to addr 6 while UNLOCKED -> wr_err=1; rd_addr 6 returns 0; addr 4 write of 12'hABC reads back 12'hABC.

Source files
------------

// File: rtl/secure_lock_pkg.sv
// Shared types and width helpers for the key-gated configuration register bank.
package secure_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    CHECK    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } lock_state_e;

  localparam logic [31:0] DEFAULT_KEY = 32'hA5C3_0F1E;

  // Index width for n entries, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int fail_w(input int max_fail);
    return ($clog2(max_fail + 1) > 0) ? $clog2(max_fail + 1) : 1;
  endfunction

endpackage

// File: rtl/secure_lock_regfile_lock_fsm.sv
// Lock state machine: captures a key, checks it one cycle later, and enforces
// a timed lockout after repeated consecutive failures.
module lock_fsm
  import secure_lock_pkg::*;
#(
  parameter int               KEY_W       = 32,
  parameter logic [KEY_W-1:0] UNLOCK_KEY  = KEY_W'(DEFAULT_KEY),
  parameter int               MAX_FAIL    = 3,
  parameter int               LOCKOUT_CYC = 16,
  localparam int              FW          = fail_w(MAX_FAIL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             unlock_req,
  input  logic [KEY_W-1:0] unlock_key,
  input  logic             lock_set,
  output logic             write_allow,
  output logic             unlocked,
  output logic             lockout,
  output logic [FW-1:0]    fail_cnt
);

  localparam int            TW         = addr_w(LOCKOUT_CYC);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYC - 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAIL);

  lock_state_e      state;
  logic [KEY_W-1:0] key_q;
  logic [TW-1:0]    timer;
  logic [FW-1:0]    fail_next;

  assign fail_next = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOCKED;
      key_q    <= '0;
      fail_cnt <= '0;
      timer    <= '0;
    end else begin
      case (state)
        LOCKED: begin
          if (unlock_req) begin
            key_q <= unlock_key;
            state <= CHECK;
          end
        end
        // Comparison uses only the captured key, never the live port.
        CHECK: begin
          if (key_q == UNLOCK_KEY) begin
            state    <= UNLOCKED;
            fail_cnt <= '0;
          end else begin
            fail_cnt <= fail_next;
            if (fail_next == FAIL_MAX) begin
              state <= LOCKOUT;
              timer <= TIMER_LOAD;
            end else begin
              state <= LOCKED;
            end
          end
        end
        UNLOCKED: begin
          if (lock_set) state <= LOCKED;
        end
        LOCKOUT: begin
          if (timer == '0) begin
            state    <= LOCKED;
            fail_cnt <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= LOCKED;
      endcase
    end
  end

  assign unlocked    = (state == UNLOCKED);
  assign lockout     = (state == LOCKOUT);
  assign write_allow = (state == UNLOCKED) && !lock_set;

endmodule

// File: rtl/secure_lock_regfile.sv
// Bank of write-protected configuration registers behind a key-gated lock.
// Reads are always open; writes need the lock open and no same-cycle relock.
module secure_lock_regfile
  import secure_lock_pkg::*;
#(
  parameter int               NUM_REGS    = 4,
  parameter int               DATA_W      = 8,
  parameter int               KEY_W       = 32,
  parameter logic [KEY_W-1:0] UNLOCK_KEY  = KEY_W'(DEFAULT_KEY),
  parameter int               MAX_FAIL    = 3,
  parameter int               LOCKOUT_CYC = 16,
  localparam int              AW          = addr_w(NUM_REGS),
  localparam int              FW          = fail_w(MAX_FAIL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              lock_set,
  input  logic              unlock_req,
  input  logic [KEY_W-1:0]  unlock_key,
  output logic              unlocked,
  output logic              lockout,
  output logic              wr_err,
  output logic [FW-1:0]     fail_cnt
);

  localparam logic [AW:0] NREGS = (AW + 1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              write_allow;
  logic              wr_ok;
  logic              rd_ok;

  lock_fsm #(
    .KEY_W      (KEY_W),
    .UNLOCK_KEY (UNLOCK_KEY),
    .MAX_FAIL   (MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC)
  ) u_lock_fsm (
    .clk        (clk),
    .reset      (reset),
    .unlock_req (unlock_req),
    .unlock_key (unlock_key),
    .lock_set   (lock_set),
    .write_allow(write_allow),
    .unlocked   (unlocked),
    .lockout    (lockout),
    .fail_cnt   (fail_cnt)
  );

  assign wr_ok = wr_en && write_allow && ({1'b0, wr_addr} < NREGS);
  assign rd_ok = ({1'b0, rd_addr} < NREGS);

  // Read samples the pre-write contents, so read-during-write returns old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rd_data <= '0;
      wr_err  <= 1'b0;
    end else begin
      wr_err  <= wr_en && !wr_ok;
      rd_data <= rd_ok ? regs[rd_addr] : '0;
      if (wr_ok) regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_secure_lock_regfile.sv
// Self-checking bench: directed scenarios then random traffic, both checked
// every cycle against a behavioural model of the lock and register bank.
module tb_secure_lock_regfile;

  localparam logic [31:0] KEY         = 32'hA5C3_0F1E;
  localparam int          MAX_FAIL    = 3;
  localparam int          LOCKOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, lock_set, unlock_req;
  logic [31:0] unlock_key;

  logic [1:0]  wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_data;
  logic        unlocked, lockout, wr_err;
  logic [1:0]  fail_cnt;

  logic [2:0]  wr_addr5, rd_addr5;
  logic [11:0] wr_data5, rd_data5;
  logic        unlocked5, lockout5, wr_err5;
  logic [1:0]  fail_cnt5;

  int vectors = 0;
  int miscompares = 0;

  // Model state: register contents plus a plain description of the lock.
  int          m_regs  [4];
  int          m_regs5 [5];
  bit          m_unl, m_chk;
  int          m_fail, m_left;
  logic [31:0] m_key;
  int          exp_rd, exp_rd5;
  bit          exp_err, exp_err5;

  always #5 clk = ~clk;

  secure_lock_regfile dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .lock_set(lock_set), .unlock_req(unlock_req),
    .unlock_key(unlock_key), .unlocked(unlocked), .lockout(lockout), .wr_err(wr_err),
    .fail_cnt(fail_cnt)
  );

  secure_lock_regfile #(.NUM_REGS(5), .DATA_W(12)) dut5 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr5), .wr_data(wr_data5),
    .rd_addr(rd_addr5), .rd_data(rd_data5), .lock_set(lock_set), .unlock_req(unlock_req),
    .unlock_key(unlock_key), .unlocked(unlocked5), .lockout(lockout5), .wr_err(wr_err5),
    .fail_cnt(fail_cnt5)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    bit acc, acc5;
    if (reset) begin
      foreach (m_regs[i])  m_regs[i]  = 0;
      foreach (m_regs5[i]) m_regs5[i] = 0;
      m_unl = 0; m_chk = 0; m_fail = 0; m_left = 0; m_key = '0;
      exp_rd = 0; exp_rd5 = 0; exp_err = 0; exp_err5 = 0;
    end else begin
      acc      = wr_en && m_unl && !lock_set;
      acc5     = acc && (wr_addr5 < 5);
      exp_err  = wr_en && !acc;
      exp_err5 = wr_en && !acc5;
      exp_rd   = m_regs[rd_addr];
      exp_rd5  = (rd_addr5 < 5) ? m_regs5[rd_addr5] : 0;
      if (acc)  m_regs[wr_addr]   = int'(wr_data);
      if (acc5) m_regs5[wr_addr5] = int'(wr_data5);
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_fail = 0;
      end else if (m_chk) begin
        m_chk = 0;
        if (m_key == KEY) begin
          m_unl  = 1;
          m_fail = 0;
        end else begin
          m_fail = (m_fail < MAX_FAIL) ? m_fail + 1 : MAX_FAIL;
          if (m_fail == MAX_FAIL) m_left = LOCKOUT_CYC;
        end
      end else if (m_unl) begin
        if (lock_set) m_unl = 0;
      end else if (unlock_req) begin
        m_chk = 1;
        m_key = unlock_key;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("unlocked",  32'(unlocked),  32'(m_unl));
    checkOutput("lockout",   32'(lockout),   32'(m_left > 0));
    checkOutput("fail_cnt",  32'(fail_cnt),  32'(m_fail));
    checkOutput("wr_err",    32'(wr_err),    32'(exp_err));
    checkOutput("rd_data",   32'(rd_data),   32'(exp_rd));
    checkOutput("unlocked5", 32'(unlocked5), 32'(m_unl));
    checkOutput("lockout5",  32'(lockout5),  32'(m_left > 0));
    checkOutput("fail_cnt5", 32'(fail_cnt5), 32'(m_fail));
    checkOutput("wr_err5",   32'(wr_err5),   32'(exp_err5));
    checkOutput("rd_data5",  32'(rd_data5),  32'(exp_rd5));
  endtask

  // One clock: inputs already set, update the model at the edge, check just after.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic setIdle();
    reset = 0; wr_en = 0; lock_set = 0; unlock_req = 0; unlock_key = '0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    wr_addr5 = '0; wr_data5 = '0; rd_addr5 = '0;
  endtask

  task automatic wrongKeys();
    for (int i = 1; i <= MAX_FAIL; i++) begin
      unlock_req = 1; unlock_key = 32'h0;
      applyStimulus();
      unlock_req = 0;
      applyStimulus();
      checkOutput("fail_cnt_step", 32'(fail_cnt), 32'(i));
    end
  endtask

  initial begin
    setIdle();
    reset = 1;
    applyStimulus();
    applyStimulus();
    checkOutput("reset_unlocked", 32'(unlocked), 32'd0);
    checkOutput("reset_fail_cnt", 32'(fail_cnt), 32'd0);
    reset = 0;

    // Write while locked is rejected.
    wr_en = 1; wr_addr = 2'd1; wr_data = 8'h5A; rd_addr = 2'd1;
    applyStimulus();
    checkOutput("locked_wr_err", 32'(wr_err), 32'd1);
    wr_en = 0;
    applyStimulus();
    checkOutput("locked_wr_err_clear", 32'(wr_err), 32'd0);
    checkOutput("locked_rd_data", 32'(rd_data), 32'd0);

    // Correct key: unlocked two cycles after the request.
    unlock_req = 1; unlock_key = KEY;
    applyStimulus();
    unlock_req = 0;
    checkOutput("unlock_latency_1", 32'(unlocked), 32'd0);
    applyStimulus();
    checkOutput("unlock_latency_2", 32'(unlocked), 32'd1);

    wr_en = 1; wr_addr = 2'd1; wr_data = 8'h5A; wr_addr5 = 3'd6; wr_data5 = 12'h123;
    rd_addr5 = 3'd6;
    applyStimulus();
    checkOutput("oob_wr_err5", 32'(wr_err5), 32'd1);
    wr_addr5 = 3'd4; wr_data5 = 12'hABC; rd_addr5 = 3'd4;
    applyStimulus();
    wr_en = 0;
    applyStimulus();
    checkOutput("rd_after_write", 32'(rd_data), 32'h5A);
    checkOutput("rd_after_write5", 32'(rd_data5), 32'hABC);
    rd_addr5 = 3'd6;
    applyStimulus();
    checkOutput("oob_rd5", 32'(rd_data5), 32'd0);

    // Relock wins over a same-cycle write.
    lock_set = 1; wr_en = 1; wr_addr = 2'd2; wr_data = 8'hFF; rd_addr = 2'd2;
    applyStimulus();
    checkOutput("lockset_wr_err", 32'(wr_err), 32'd1);
    checkOutput("lockset_unlocked", 32'(unlocked), 32'd0);
    lock_set = 0; wr_en = 0;
    applyStimulus();
    checkOutput("lockset_reg2", 32'(rd_data), 32'd0);

    // Lockout after repeated wrong keys; correct key ignored during lockout.
    wrongKeys();
    checkOutput("lockout_entered", 32'(lockout), 32'd1);
    unlock_req = 1; unlock_key = KEY;
    applyStimulus();
    unlock_req = 0;
    for (int i = 0; i < LOCKOUT_CYC - 2; i++) applyStimulus();
    checkOutput("lockout_last_cycle", 32'(lockout), 32'd1);
    applyStimulus();
    checkOutput("lockout_released", 32'(lockout), 32'd0);
    checkOutput("lockout_fail_clear", 32'(fail_cnt), 32'd0);
    checkOutput("lockout_still_locked", 32'(unlocked), 32'd0);

    // Reset in the middle of a lockout.
    wrongKeys();
    for (int i = 0; i < 8; i++) applyStimulus();
    reset = 1; rd_addr = 2'd1;
    applyStimulus();
    reset = 0;
    checkOutput("midlock_reset_lockout", 32'(lockout), 32'd0);
    checkOutput("midlock_reset_fail", 32'(fail_cnt), 32'd0);
    applyStimulus();
    checkOutput("midlock_reset_reg1", 32'(rd_data), 32'd0);
    unlock_req = 1; unlock_key = KEY;
    applyStimulus();
    unlock_req = 0;
    applyStimulus();
    checkOutput("post_reset_unlock", 32'(unlocked), 32'd1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 149) == 0);
      wr_en      = $urandom_range(0, 1) == 1;
      lock_set   = ($urandom_range(0, 11) == 0);
      unlock_req = ($urandom_range(0, 3) == 0);
      unlock_key = ($urandom_range(0, 1) == 1) ? KEY : 32'($urandom);
      wr_addr    = 2'($urandom_range(0, 3));
      rd_addr    = 2'($urandom_range(0, 3));
      wr_data    = 8'($urandom);
      wr_addr5   = 3'($urandom_range(0, 7));
      rd_addr5   = 3'($urandom_range(0, 7));
      wr_data5   = 12'($urandom);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
